// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared types and address helpers for the direct-mapped, write-through,
// no-write-allocate data cache controller.
//   - dcache_state_t : controller FSM states (2-bit encoding)
//   - ADDR_W / INDEX_W / OFFSET_W / TAG_W / LINES / WSEL_W geometry constants
//   - addr_tag / addr_index / addr_word / block_align : byte-address slicing
// -----------------------------------------------------------------------------
package dcache_pkg;

    localparam int ADDR_W   = 32;
    localparam int INDEX_W  = 6;
    localparam int OFFSET_W = 4;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES    = 1 << INDEX_W;
    localparam int WSEL_W   = OFFSET_W - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        FILL    = 2'd2,
        WR_THRU = 2'd3
    } dcache_state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return a[2 +: WSEL_W];
    endfunction

    function automatic logic [ADDR_W-1:0] block_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_tag_store.sv
// -----------------------------------------------------------------------------
// dcache_tag_store
// Valid bit vector plus tag array for the direct-mapped data cache.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset (clears every valid bit)
//   rd_index_i     : combinational read port line select
//   rd_valid_o     : valid bit of the selected line
//   rd_tag_o       : stored tag of the selected line
//   wr_en_i        : write strobe (sets valid and stores the tag)
//   wr_index_i     : write port line select
//   wr_tag_i       : tag to store
// -----------------------------------------------------------------------------
module dcache_tag_store
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_index_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tags carry no reset; a line is only trusted once its valid bit is set.
    // The write is blocked during reset so an interrupted fill leaves nothing.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];

endmodule

// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
// Sequencing FSM for the direct-mapped, write-through, no-write-allocate data
// cache between the MEM stage and main memory.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   cpu_mem_read/_write   : load / store request, held by the CPU while stall=1
//   cpu_addr              : byte address from the ALU
//   stall                 : freeze PC and pipeline registers
//   hit                   : valid & tag match for cpu_addr (combinational)
//   mem_req, mem_we       : memory request (held until mem_ready), 1=word store
//   mem_addr              : block-aligned address for reads, word address for stores
//   mem_ready             : memory done (block data valid for reads)
//   data_index            : data-array line select
//   data_word_sel         : word within the line
//   data_we_line          : write full line from the memory block bus
//   data_we_word          : write one word from store data
//   dbg_state             : current FSM state
// Optional feature macro DCACHE_PERF_CNT_EN adds hit_cnt / miss_cnt outputs
// (saturating 32-bit counters, cleared by rst_n).
//
// Handshake: mem_req rises on entry to RD_MISS/WR_THRU and mem_req/mem_we/
// mem_addr stay constant until the cycle in which mem_ready=1; the transfer
// completes at that clock edge. mem_ready in any other state is ignored.
// -----------------------------------------------------------------------------
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_mem_read,
    input  logic                cpu_mem_write,
    input  logic [ADDR_W-1:0]   cpu_addr,
    output logic                stall,
    output logic                hit,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ready,
    output logic [INDEX_W-1:0]  data_index,
    output logic [WSEL_W-1:0]   data_word_sel,
    output logic                data_we_line,
    output logic                data_we_word,
    output dcache_state_t       dbg_state
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
`endif
);

    dcache_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              lhit_q, lhit_d;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic              addr_lsb_unused;

    // Byte-lane bits are not part of the cache lookup.
    assign addr_lsb_unused = ^cpu_addr[1:0];

    dcache_tag_store u_tag_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_index_i (addr_index(cpu_addr)),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .wr_en_i    (state_q == FILL),
        .wr_index_i (addr_index(addr_q)),
        .wr_tag_i   (addr_tag(addr_q))
    );

    assign hit = rd_valid && (rd_tag == addr_tag(cpu_addr));

    // Outside IDLE the data array follows the latched request so the CPU
    // address may not influence an in-flight fill or store.
    assign data_index    = (state_q == IDLE) ? addr_index(cpu_addr) : addr_index(addr_q);
    assign data_word_sel = (state_q == IDLE) ? addr_word(cpu_addr)  : addr_word(addr_q);
    assign dbg_state     = state_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lhit_d       = lhit_q;
        stall        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        data_we_line = 1'b0;
        data_we_word = 1'b0;
        case (state_q)
            IDLE: begin
                // A store takes priority over a simultaneous load.
                if (cpu_mem_write) begin
                    stall   = 1'b1;
                    addr_d  = cpu_addr;
                    lhit_d  = hit;
                    state_d = WR_THRU;
                end else if (cpu_mem_read && !hit) begin
                    stall   = 1'b1;
                    addr_d  = cpu_addr;
                    state_d = RD_MISS;
                end
            end
            RD_MISS: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = block_align(addr_q);
                if (mem_ready) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                // The load is replayed from IDLE next cycle and hits there.
                stall        = 1'b1;
                data_we_line = 1'b1;
                state_d      = IDLE;
            end
            WR_THRU: begin
                // Releasing stall in the ready cycle retires the store at the
                // same edge the memory accepts it.
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = addr_q;
                stall        = !mem_ready;
                data_we_word = mem_ready && lhit_q;
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lhit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lhit_q  <= lhit_d;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic        fill_retry_q;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        count_hit, count_miss;

    // The IDLE cycle right after FILL replays an already-counted miss, so it
    // is not counted again as a hit.
    assign count_hit  = (state_q == IDLE) && !fill_retry_q && hit &&
                        (cpu_mem_read || cpu_mem_write);
    assign count_miss = (state_q == IDLE) && !hit && (cpu_mem_read || cpu_mem_write);

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (count_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (count_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_retry_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            fill_retry_q <= (state_q == FILL);
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;
    import dcache_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic                cpu_mem_read;
    logic                cpu_mem_write;
    logic [ADDR_W-1:0]   cpu_addr;
    logic                stall;
    logic                hit;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ready;
    logic [INDEX_W-1:0]  data_index;
    logic [WSEL_W-1:0]   data_word_sel;
    logic                data_we_line;
    logic                data_we_word;
    dcache_state_t       dbg_state;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]         hit_cnt;
    logic [31:0]         miss_cnt;
`endif

    dcache_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_mem_read  (cpu_mem_read),
        .cpu_mem_write (cpu_mem_write),
        .cpu_addr      (cpu_addr),
        .stall         (stall),
        .hit           (hit),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .data_index    (data_index),
        .data_word_sel (data_word_sel),
        .data_we_line  (data_we_line),
        .data_we_word  (data_we_word),
        .dbg_state     (dbg_state)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Full read-miss sequence: miss in IDLE, `waits` RD_MISS cycles without
    // mem_ready, one with it, FILL, then the replayed hit.
    task automatic do_read_miss(input logic [31:0] a, input int waits, input string t);
        @(negedge clk);
        cpu_mem_read  = 1'b1;
        cpu_mem_write = 1'b0;
        cpu_addr      = a;
        #1;
        check({t, "_miss_hit"}, 32'(hit), 32'd0);
        check({t, "_miss_stall"}, 32'(stall), 32'd1);
        check({t, "_miss_idle_req"}, 32'(mem_req), 32'd0);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            #1;
            check({t, "_rd_req"}, 32'(mem_req), 32'd1);
            check({t, "_rd_we"}, 32'(mem_we), 32'd0);
            check({t, "_rd_addr"}, mem_addr, a & 32'hFFFF_FFF0);
            check({t, "_rd_stall"}, 32'(stall), 32'd1);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check({t, "_rd_state"}, 32'(dbg_state), 32'(RD_MISS));
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check({t, "_fill_state"}, 32'(dbg_state), 32'(FILL));
        check({t, "_fill_we_line"}, 32'(data_we_line), 32'd1);
        check({t, "_fill_stall"}, 32'(stall), 32'd1);
        check({t, "_fill_req"}, 32'(mem_req), 32'd0);
        check({t, "_fill_index"}, 32'(data_index), (a >> 4) & 32'h3F);
        @(negedge clk);
        #1;
        check({t, "_after_hit"}, 32'(hit), 32'd1);
        check({t, "_after_stall"}, 32'(stall), 32'd0);
        check({t, "_after_we_line"}, 32'(data_we_line), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        cpu_mem_read  = 1'b0;
        cpu_mem_write = 1'b0;
        cpu_addr      = '0;
        mem_ready     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_we_line", 32'(data_we_line), 32'd0);
        check("rst_we_word", 32'(data_we_word), 32'd0);

        // Test 1: read miss at 0x40, mem_ready in the third RD_MISS cycle.
        do_read_miss(32'h0000_0040, 2, "t1");

        // Test 2: read 0x44 hits in the same line.
        @(negedge clk);
        cpu_addr = 32'h0000_0044;
        #1;
        check("t2_hit", 32'(hit), 32'd1);
        check("t2_stall", 32'(stall), 32'd0);
        check("t2_req", 32'(mem_req), 32'd0);
        check("t2_word_sel", 32'(data_word_sel), 32'd1);

        // Test 3: write hit at 0x48, then write miss at 0x1048.
        @(negedge clk);
`ifdef DCACHE_PERF_CNT_EN
        check("t6_hit_cnt", hit_cnt, 32'd1);
        check("t6_miss_cnt", miss_cnt, 32'd1);
`endif
        cpu_mem_read  = 1'b0;
        cpu_mem_write = 1'b1;
        cpu_addr      = 32'h0000_0048;
        #1;
        check("t3_wr_hit", 32'(hit), 32'd1);
        check("t3_wr_idle_stall", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        check("t3_wr_req", 32'(mem_req), 32'd1);
        check("t3_wr_we", 32'(mem_we), 32'd1);
        check("t3_wr_addr", mem_addr, 32'h0000_0048);
        check("t3_wr_stall", 32'(stall), 32'd1);
        check("t3_wr_we_word_wait", 32'(data_we_word), 32'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("t3_wr_ready_stall", 32'(stall), 32'd0);
        check("t3_wr_we_word", 32'(data_we_word), 32'd1);
        check("t3_wr_word_sel", 32'(data_word_sel), 32'd2);
        check("t3_wr_ready_addr", mem_addr, 32'h0000_0048);
        @(negedge clk);
        mem_ready = 1'b0;
        cpu_addr  = 32'h0000_1048;
        #1;
        check("t3_wm_state", 32'(dbg_state), 32'(IDLE));
        check("t3_wm_hit", 32'(hit), 32'd0);
        check("t3_wm_stall", 32'(stall), 32'd1);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("t3_wm_addr", mem_addr, 32'h0000_1048);
        check("t3_wm_we_word", 32'(data_we_word), 32'd0);
        check("t3_wm_stall", 32'(stall), 32'd0);
        @(negedge clk);
        mem_ready     = 1'b0;
        cpu_mem_write = 1'b0;
        cpu_mem_read  = 1'b1;
        cpu_addr      = 32'h0000_0040;
        #1;
        check("t3_valid_kept", 32'(hit), 32'd1);
        check("t3_valid_kept_stall", 32'(stall), 32'd0);

        // Test 4: fill 0x0, replace with 0x400 (same index), 0x0 misses again.
        do_read_miss(32'h0000_0000, 0, "t4a");
        do_read_miss(32'h0000_0400, 1, "t4b");
        @(negedge clk);
        cpu_addr = 32'h0000_0000;
        #1;
        check("t4_reread_hit", 32'(hit), 32'd0);
        check("t4_reread_stall", 32'(stall), 32'd1);

        // Test 5: reset while in RD_MISS.
        @(negedge clk);
        #1;
        check("t5_rdmiss_state", 32'(dbg_state), 32'(RD_MISS));
        check("t5_rdmiss_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("t5_rst_req", 32'(mem_req), 32'd0);
        check("t5_rst_state", 32'(dbg_state), 32'(IDLE));
        check("t5_rst_we_line", 32'(data_we_line), 32'd0);
        rst_n        = 1'b1;
        cpu_mem_read = 1'b0;
        do_read_miss(32'h0000_0040, 1, "t5");

        // Test 6: read and write together take the store path.
        @(negedge clk);
        cpu_mem_read  = 1'b1;
        cpu_mem_write = 1'b1;
        cpu_addr      = 32'h0000_0040;
        #1;
        check("t6_rw_hit", 32'(hit), 32'd1);
        check("t6_rw_stall", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        check("t6_rw_state", 32'(dbg_state), 32'(WR_THRU));
        check("t6_rw_mem_we", 32'(mem_we), 32'd1);
        mem_ready = 1'b1;
        #1;
        check("t6_rw_we_word", 32'(data_we_word), 32'd1);
        @(negedge clk);
        mem_ready     = 1'b0;
        cpu_mem_read  = 1'b0;
        cpu_mem_write = 1'b0;
        #1;
        check("t6_rw_back_idle", 32'(dbg_state), 32'(IDLE));

        // mem_ready with no request pending is ignored.
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("stray_ready_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("stray_ready_state", 32'(dbg_state), 32'(IDLE));

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
